// File: rtl/fp_pkg.sv
// Shared constants, FSM state type and field helpers for the iterative FP multiplier.
package fp_pkg;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int BIAS   = 127;
  localparam int FP_W   = 1 + EXP_W + MANT_W;

  localparam logic [FP_W-1:0] QNAN    = 32'h7FC00000;
  localparam logic [FP_W-1:0] POS_INF = 32'h7F800000;

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  function automatic logic f_sign(input logic [FP_W-1:0] x);
    return x[FP_W-1];
  endfunction

  function automatic logic [EXP_W-1:0] f_exp(input logic [FP_W-1:0] x);
    return x[FP_W-2 -: EXP_W];
  endfunction

  function automatic logic [MANT_W-1:0] f_mant(input logic [FP_W-1:0] x);
    return x[MANT_W-1:0];
  endfunction
endpackage

// File: rtl/fp_mul_iter_special.sv
// Operand classification and special-result select; subnormal inputs count as zero.
module fp_mul_iter_special
  import fp_pkg::*;
(
  input  logic [FP_W-1:0] a_i,
  input  logic [FP_W-1:0] b_i,
  output logic            special_o,
  output logic [FP_W-1:0] result_o
);
  logic [EXP_W-1:0]  ea, eb;
  logic [MANT_W-1:0] ma, mb;
  logic za, zb, ia, ib, na, nb, sign;

  always_comb begin
    ea   = f_exp(a_i);
    eb   = f_exp(b_i);
    ma   = f_mant(a_i);
    mb   = f_mant(b_i);
    sign = f_sign(a_i) ^ f_sign(b_i);
    za   = (ea == '0);
    zb   = (eb == '0);
    ia   = (&ea) && (ma == '0);
    ib   = (&eb) && (mb == '0);
    na   = (&ea) && (ma != '0);
    nb   = (&eb) && (mb != '0);
    special_o = za | zb | ia | ib | na | nb;
    result_o  = '0;
    if (na || nb || (za && ib) || (ia && zb))
      result_o = QNAN;
    else if (ia || ib)
      result_o = {sign, POS_INF[FP_W-2:0]};
    else if (za || zb)
      result_o = {sign, {(FP_W-1){1'b0}}};
  end
endmodule

// File: rtl/fp_mul_iter.sv
// Sequential IEEE-754 single multiplier: radix-2 shift-add over 24 cycles, then normalise.
// Define FP_MUL_ITER_ROUND_EN for round-to-nearest-even; otherwise the result is truncated.
module fp_mul_iter
  import fp_pkg::*;
#(
  parameter int EXP_W  = fp_pkg::EXP_W,
  parameter int MANT_W = fp_pkg::MANT_W,
  parameter int BIAS   = fp_pkg::BIAS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [EXP_W+MANT_W:0]   data_iA,
  input  logic [EXP_W+MANT_W:0]   data_iB,
  output logic                    busy,
  output logic                    done,
  output logic [EXP_W+MANT_W:0]   data_o
);
  localparam int W     = 1 + EXP_W + MANT_W;
  localparam int MW    = MANT_W + 1;
  localparam int PW    = 2 * MW;
  localparam int XW    = EXP_W + 2;
  localparam int CNT_W = $clog2(MW);
  localparam logic [CNT_W-1:0]     LAST    = CNT_W'(MW - 1);
  localparam logic signed [XW-1:0] BIAS_X  = XW'(BIAS);
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] ZERO_X  = '0;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [PW-1:0]          acc_q, acc_d;
  logic [MW-1:0]          mcand_q;
  logic signed [XW-1:0]   exp_q;
  logic                   sign_q, busy_q, done_q;
  logic [W-1:0]           data_q;

  logic                   spec;
  logic [W-1:0]           spec_res;

  fp_mul_iter_special u_special (
    .a_i       (data_iA),
    .b_i       (data_iB),
    .special_o (spec),
    .result_o  (spec_res)
  );

  // Upper half accumulates, lower half holds the remaining multiplier bits.
  logic [MW-1:0] addend;
  logic [MW:0]   sum;
  always_comb begin
    addend = acc_q[0] ? mcand_q : '0;
    sum    = {1'b0, acc_q[PW-1:MW]} + {1'b0, addend};
    acc_d  = {sum, acc_q[MW-1:1]};
  end

  logic                 hi;
  logic [MANT_W-1:0]    mant, mant_r;
  logic signed [XW-1:0] exp_n, exp_f;
  logic [W-1:0]         norm_res;
`ifdef FP_MUL_ITER_ROUND_EN
  logic guard, sticky, rnd, carry;
`endif

  always_comb begin
    hi    = acc_q[PW-1];
    mant  = hi ? acc_q[PW-2 -: MANT_W] : acc_q[PW-3 -: MANT_W];
    exp_n = exp_q + XW'(hi);
`ifdef FP_MUL_ITER_ROUND_EN
    guard  = hi ? acc_q[PW-2-MANT_W] : acc_q[PW-3-MANT_W];
    sticky = hi ? |acc_q[PW-3-MANT_W:0] : |acc_q[PW-4-MANT_W:0];
    rnd    = guard & (sticky | mant[0]);
    {carry, mant_r} = {1'b0, mant} + {{MANT_W{1'b0}}, rnd};
    exp_f  = exp_n + XW'(carry);
`else
    mant_r = mant;
    exp_f  = exp_n;
`endif
    if (exp_f >= EXP_MAX)
      norm_res = {sign_q, POS_INF[W-2:0]};
    else if (exp_f <= ZERO_X)
      norm_res = {sign_q, {(W-1){1'b0}}};
    else
      norm_res = {sign_q, exp_f[EXP_W-1:0], mant_r};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          busy_q <= 1'b1;
          sign_q <= f_sign(data_iA) ^ f_sign(data_iB);
          if (spec) begin
            data_q  <= spec_res;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            acc_q   <= {{MW{1'b0}}, 1'b1, f_mant(data_iA)};
            mcand_q <= {1'b1, f_mant(data_iB)};
            exp_q   <= XW'(f_exp(data_iA)) + XW'(f_exp(data_iB)) - BIAS_X;
            cnt_q   <= '0;
            state_q <= MUL;
          end
        end
        MUL: begin
          acc_q <= acc_d;
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= NORM;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        NORM: begin
          data_q  <= norm_res;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign data_o = data_q;
endmodule

// File: tb/tb_fp_mul_iter.sv
// Scoreboard bench for fp_mul_iter: stimulus pushes expected results, a monitor checks on done.
module tb_fp_mul_iter;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] data_o;

  int checks = 0, errors = 0, cyc = 0;

  typedef struct {
    logic [31:0] data;
    int          issue;
    int          lat;
    string       name;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    logic [31:0] a, b, e;
    int          lat;
  } vec_t;

`ifdef FP_MUL_ITER_ROUND_EN
  localparam logic [31:0] RND_EXP = 32'h3FC00002;
`else
  localparam logic [31:0] RND_EXP = 32'h3FC00001;
`endif

  vec_t vecs[9] = '{
    '{32'h40400000, 32'hC0400000, 32'hC1100000, 25},
    '{32'h7F000000, 32'h7F000000, 32'h7F800000, 25},
    '{32'h00800000, 32'h00800000, 32'h00000000, 25},
    '{32'h7F800000, 32'h00000000, 32'h7FC00000, 0},
    '{32'h3FC00000, 32'h3F800001, RND_EXP,      25},
    '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 0},
    '{32'h80000000, 32'h3F800000, 32'h80000000, 0},
    '{32'hFF800000, 32'h40000000, 32'hFF800000, 0},
    '{32'hC0000000, 32'h3F000000, 32'hBF800000, 25}
  };

  fp_mul_iter dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_iA (a),
    .data_iB (b),
    .busy    (busy),
    .done    (done),
    .data_o  (data_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got %h want no done", data_o);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_data"}, data_o, mon_e.data);
        chk({mon_e.name, "_latency"}, 32'(cyc - mon_e.issue), 32'(mon_e.lat));
      end
    end
  end

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] ev,
                       input int lat, input string nm);
    exp_t e;
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    @(posedge clk);
    #1;
    e.data = ev; e.issue = cyc; e.lat = lat; e.name = nm;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse(input logic [31:0] ia, input logic [31:0] ib);
    a = ia; b = ib; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout got %0d pending want 0", nm, sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_data", data_o, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1.5 * 2 with busy held through all 26 cycles
    issue(32'h3FC00000, 32'h40000000, 32'h40400000, 25, "t1");
    for (int k = 1; k <= 26; k++) begin
      chk($sformatf("t1_busy_c%0d", k), 32'(busy), 32'd1);
      @(negedge clk);
    end
    chk("t1_busy_after", 32'(busy), 32'd0);
    wait_idle("t1");
    chk("t1_hold", data_o, 32'h40400000);

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].e, vecs[i].lat, $sformatf("vec%0d", i));
      wait_idle($sformatf("vec%0d", i));
    end

    // start while busy (MUL) and in the DONE cycle must be ignored
    issue(32'h3FC00000, 32'h40000000, 32'h40400000, 25, "t5");
    repeat (4) @(negedge clk);
    pulse(32'h40400000, 32'hC0400000);
    repeat (6) @(negedge clk);
    pulse(32'h40400000, 32'hC0400000);
    repeat (13) @(negedge clk);
    pulse(32'h40400000, 32'hC0400000);
    wait_idle("t5");
    repeat (30) @(negedge clk);
    chk("t5_hold", data_o, 32'h40400000);
    chk("t5_idle", 32'(busy), 32'd0);

    // reset in MUL cycle 10 aborts without done
    issue(32'h40400000, 32'hC0400000, 32'hC1100000, 25, "t6");
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_data", data_o, 32'h0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    issue(32'h40400000, 32'hC0400000, 32'hC1100000, 25, "t6_after");
    wait_idle("t6_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
